// File: rtl/configs_loader.sv
// Serial-to-parallel loader for the per-tile configuration latch bank.
// Assembles serial config bits into words and pulses one latch enable per word with a hold guard.
module configs_loader #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 10,
   parameter int IDX_W     = 4,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic                 io_cfg_in,
   input  logic                 io_cfg_valid,
   output logic                 io_cfg_ready,
   output logic [WORD_W-1:0]    io_d_out,
   output logic [NUM_WORDS-1:0] io_configs_en,
   output logic [IDX_W-1:0]     io_word_idx,
   output logic                 io_busy,
   output logic                 io_done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [WORD_W-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]     word_idx_q, word_idx_d;
   logic [WORD_W-1:0]    d_out_q, d_out_d;
   logic [NUM_WORDS-1:0] en_q, en_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WORD_W-1:0]    shifted;

   assign shifted = {io_cfg_in, shift_q[WORD_W-1:1]};

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      word_idx_d = word_idx_q;
      d_out_d    = d_out_q;
      en_d       = '0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (io_start) begin
               state_d    = ST_SHIFT;
               shift_d    = '0;
               bit_cnt_d  = '0;
               word_idx_d = '0;
            end
         end
         ST_SHIFT: begin
            if (io_cfg_valid && ready_q) begin
               shift_d = shifted;
               if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                  // Data and enable launch on the same edge; the latch sees a settled word.
                  state_d   = ST_WRITE;
                  d_out_d   = shifted;
                  en_d      = NUM_WORDS'(1) << word_idx_q;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WRITE: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (word_idx_q == IDX_W'(NUM_WORDS - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d    = ST_SHIFT;
               word_idx_d = word_idx_q + IDX_W'(1);
               bit_cnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_SHIFT);
      busy_d  = (state_d == ST_SHIFT) || (state_d == ST_WRITE) || (state_d == ST_HOLD);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         word_idx_q <= '0;
         d_out_q    <= '0;
         en_q       <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         word_idx_q <= word_idx_d;
         d_out_q    <= d_out_d;
         en_q       <= en_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign io_cfg_ready  = ready_q;
   assign io_d_out      = d_out_q;
   assign io_configs_en = en_q;
   assign io_word_idx   = word_idx_q;
   assign io_busy       = busy_q;
   assign io_done       = done_q;

endmodule
